// File: rtl/bus_read_y.sv
// Y-matrix row reader: fetches a diagonal and a non-diagonal Y SRAM row while the bus
// grant is held and extracts one complex element from each row by one-hot slot select.
module bus_read_y #(
    parameter int                ADDR_W    = 11,
    parameter int                DATA_W    = 256,
    parameter int                SLOT_W    = 64,
    parameter int                ELEM_W    = 48,
    parameter int                READ_LAT  = 1,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = 11'h7ff
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inModuleEnable,
    input  logic              startReq,
    input  logic [ADDR_W-1:0] inDiagAddr,
    input  logic [ADDR_W-1:0] inNonDAddr,
    input  logic [3:0]        inDiagOH,
    input  logic [3:0]        inNonDiagOH,
    input  logic [DATA_W-1:0] inYreadData1,
    input  logic [DATA_W-1:0] inYreadData2,
    output logic [ADDR_W-1:0] op_readAddr1,
    output logic [ADDR_W-1:0] op_readAddr2,
    output logic [ELEM_W-1:0] op_diagVal,
    output logic [ELEM_W-1:0] op_nonDiagVal,
    output logic              op_readDone,
    output logic              op_busy,
    output logic              op_ohError
);

    localparam int NSLOT = 4;
    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   daddr_q, daddr_d, naddr_q, naddr_d;
    logic [NSLOT-1:0]    doh_q, doh_d, noh_q, noh_d;
    logic [ADDR_W-1:0]   rd1_q, rd1_d, rd2_q, rd2_d;
    logic [ELEM_W-1:0]   dval_q, dval_d, nval_q, nval_d;
    logic                done_q, done_d, busy_q, busy_d, oherr_q, oherr_d;

    // Upper bits of each slot carry no element data.
    logic unused_hi;
    assign unused_hi = ^{inYreadData1, inYreadData2};

    function automatic logic [ELEM_W-1:0] extract(input logic [DATA_W-1:0] row,
                                                   input logic [NSLOT-1:0]  oh);
        logic [ELEM_W-1:0] r;
        r = '0;
        for (int k = 0; k < NSLOT; k++)
            if (oh[k]) r = r | row[k*SLOT_W +: ELEM_W];
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        daddr_d = daddr_q;
        naddr_d = naddr_q;
        doh_d   = doh_q;
        noh_d   = noh_q;
        dval_d  = dval_q;
        nval_d  = nval_q;
        oherr_d = oherr_q;
        case (state_q)
            S_IDLE: begin
                if (startReq) begin
                    daddr_d = inDiagAddr;
                    naddr_d = inNonDAddr;
                    doh_d   = inDiagOH;
                    noh_d   = inNonDiagOH;
                    if (!$onehot(inDiagOH) || !$onehot(inNonDiagOH)) begin
                        // Bad select: finish immediately without touching the SRAM.
                        oherr_d = 1'b1;
                        dval_d  = '0;
                        nval_d  = '0;
                        state_d = S_DONE;
                    end else begin
                        oherr_d = 1'b0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (inModuleEnable) begin
                    cnt_d   = CNT_W'(READ_LAT - 1);
                    state_d = (READ_LAT == 1) ? S_CAPTURE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!inModuleEnable) begin
                    state_d = S_ISSUE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!inModuleEnable) begin
                    state_d = S_ISSUE;
                end else begin
                    dval_d  = extract(inYreadData1, doh_q);
                    nval_d  = extract(inYreadData2, noh_q);
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        if (state_d == S_ISSUE || state_d == S_WAIT || state_d == S_CAPTURE) begin
            rd1_d = daddr_d;
            rd2_d = naddr_d;
        end else begin
            rd1_d = IDLE_ADDR;
            rd2_d = IDLE_ADDR;
        end
        done_d = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            daddr_q <= '0;
            naddr_q <= '0;
            doh_q   <= '0;
            noh_q   <= '0;
            rd1_q   <= IDLE_ADDR;
            rd2_q   <= IDLE_ADDR;
            dval_q  <= '0;
            nval_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            oherr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            daddr_q <= daddr_d;
            naddr_q <= naddr_d;
            doh_q   <= doh_d;
            noh_q   <= noh_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            dval_q  <= dval_d;
            nval_q  <= nval_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            oherr_q <= oherr_d;
        end
    end

    assign op_readAddr1  = rd1_q;
    assign op_readAddr2  = rd2_q;
    assign op_diagVal    = dval_q;
    assign op_nonDiagVal = nval_q;
    assign op_readDone   = done_q;
    assign op_busy       = busy_q;
    assign op_ohError    = oherr_q;

endmodule

// File: tb/tb_bus_read_y.sv
// Randomized bench for bus_read_y: SRAM model with fixed latency plus a transaction-level
// reference (done arrives once the grant has been held for READ_LAT+1 consecutive cycles).
module tb_bus_read_y;

    localparam int LAT = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         inModuleEnable = 1'b0;
    logic         startReq = 1'b0;
    logic [10:0]  inDiagAddr = '0, inNonDAddr = '0;
    logic [3:0]   inDiagOH = '0, inNonDiagOH = '0;
    logic [255:0] inYreadData1, inYreadData2;
    logic [10:0]  op_readAddr1, op_readAddr2;
    logic [47:0]  op_diagVal, op_nonDiagVal;
    logic         op_readDone, op_busy, op_ohError;

    logic [255:0] mem1 [2048];
    logic [255:0] mem2 [2048];
    logic [10:0]  p1 [LAT] = '{default: 11'h7ff};
    logic [10:0]  p2 [LAT] = '{default: 11'h7ff};

    int          n_chk = 0, n_pass = 0;
    logic [47:0] cur_d = '0, cur_n = '0;

    bus_read_y #(.READ_LAT(LAT)) dut (
        .clock(clock), .reset(reset), .inModuleEnable(inModuleEnable), .startReq(startReq),
        .inDiagAddr(inDiagAddr), .inNonDAddr(inNonDAddr), .inDiagOH(inDiagOH),
        .inNonDiagOH(inNonDiagOH), .inYreadData1(inYreadData1), .inYreadData2(inYreadData2),
        .op_readAddr1(op_readAddr1), .op_readAddr2(op_readAddr2), .op_diagVal(op_diagVal),
        .op_nonDiagVal(op_nonDiagVal), .op_readDone(op_readDone), .op_busy(op_busy),
        .op_ohError(op_ohError)
    );

    always #5 clock = ~clock;

    // SRAM: data for an address appears LAT cycles after the address is driven.
    always @(posedge clock) begin
        p1[0] <= op_readAddr1;
        p2[0] <= op_readAddr2;
        for (int i = 1; i < LAT; i++) begin
            p1[i] <= p1[i-1];
            p2[i] <= p2[i-1];
        end
    end
    assign inYreadData1 = mem1[p1[LAT-1]];
    assign inYreadData2 = mem2[p2[LAT-1]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [47:0] slot(input logic [255:0] row, input logic [3:0] oh);
        for (int i = 0; i < 4; i++)
            if (oh[i]) return row[i*64 +: 48];
        return '0;
    endfunction

    function automatic logic grant(input int mode, input int k);
        case (mode)
            1:       return 1'b1;
            2:       return (k > 3);
            3:       return (k != LAT + 1);
            default: return ($urandom % 4) != 0;
        endcase
    endfunction

    function automatic logic [3:0] rand_oh(input bit valid);
        logic [3:0] x;
        if (valid) return 4'(1 << ($urandom % 4));
        do x = 4'($urandom); while ($countones(x) == 1);
        return x;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after DONE.
    task automatic run_req(input logic [10:0] da, input logic [10:0] na,
                           input logic [3:0] doh, input logic [3:0] noh, input int gmode);
        bit          inval;
        int          k, run, dk;
        bit          fin;
        logic [47:0] ed, en;
        logic        g;
        inval = ($countones(doh) != 1) || ($countones(noh) != 1);
        ed = inval ? 48'h0 : slot(mem1[da], doh);
        en = inval ? 48'h0 : slot(mem2[na], noh);
        startReq = 1'b1; inDiagAddr = da; inNonDAddr = na;
        inDiagOH = doh; inNonDiagOH = noh; inModuleEnable = 1'($urandom);
        @(posedge clock);
        dk = inval ? 1 : -1;
        run = 0;
        fin = 0;
        for (k = 1; k <= 200; k++) begin
            @(negedge clock);
            chk("done", op_readDone, (k == dk));
            chk("busy", op_busy, (dk < 0 || k <= dk));
            chk("oherr", op_ohError, inval);
            chk("addr1", op_readAddr1, (!inval && (dk < 0 || k < dk)) ? da : 11'h7ff);
            chk("addr2", op_readAddr2, (!inval && (dk < 0 || k < dk)) ? na : 11'h7ff);
            if (dk > 0 && k >= dk) begin
                chk("diagval", op_diagVal, ed);
                chk("nondval", op_nonDiagVal, en);
            end
            if (dk > 0 && k == dk + 1) begin
                fin = 1;
                break;
            end
            // Noise on request inputs while busy must be ignored.
            startReq = 1'($urandom); inDiagAddr = 11'($urandom); inNonDAddr = 11'($urandom);
            inDiagOH = 4'($urandom); inNonDiagOH = 4'($urandom);
            g = grant(gmode, k);
            inModuleEnable = g;
            if (!inval && dk < 0) begin
                run = g ? run + 1 : 0;
                if (run == LAT + 1) dk = k + 1;
            end
        end
        if (!fin) chk("timeout", fin, 1);
        cur_d = ed;
        cur_n = en;
        startReq = 1'b0;
    endtask

    initial begin
        logic [10:0] a, b;
        for (int i = 0; i < 2048; i++)
            for (int j = 0; j < 8; j++) begin
                mem1[i][j*32 +: 32] = $urandom;
                mem2[i][j*32 +: 32] = $urandom;
            end
        mem1[11'h012][63:0]    = 64'h000A_BCDE_F012_3456;
        mem2[11'h034][191:128] = 64'h0000_1111_2222_3333;

        repeat (3) @(negedge clock);
        chk("rst_addr1", op_readAddr1, 11'h7ff);
        chk("rst_addr2", op_readAddr2, 11'h7ff);
        chk("rst_busy", op_busy, 0);
        chk("rst_done", op_readDone, 0);
        chk("rst_err", op_ohError, 0);
        chk("rst_vals", {op_diagVal, op_nonDiagVal}, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_busy", op_busy, 0);
        chk("idle_addr1", op_readAddr1, 11'h7ff);

        run_req(11'h012, 11'h034, 4'b0001, 4'b0100, 1);
        chk("ex_diag", op_diagVal, 48'hBCDE_F012_3456);
        chk("ex_nond", op_nonDiagVal, 48'h1111_2222_3333);
        run_req(11'h012, 11'h034, 4'b0001, 4'b0100, 2);
        run_req(11'h155, 11'h155, 4'b1000, 4'b0010, 3);
        run_req(11'h012, 11'h034, 4'b0011, 4'b0100, 1);
        run_req(11'h034, 11'h012, 4'b0100, 4'b0001, 1);
        run_req(11'h001, 11'h002, 4'b0001, 4'b0000, 0);

        for (int t = 0; t < 40; t++) begin
            a = 11'($urandom);
            b = ($urandom % 4 == 0) ? a : 11'($urandom);
            run_req(a, b, rand_oh(($urandom % 5) != 0), rand_oh(($urandom % 5) != 0), 0);
        end

        // Reset while in WAIT: back to IDLE, no done pulse, values cleared.
        run_req(11'h0aa, 11'h0bb, 4'b0010, 4'b1000, 1);
        startReq = 1'b1; inDiagAddr = 11'h123; inNonDAddr = 11'h321;
        inDiagOH = 4'b0001; inNonDiagOH = 4'b0001; inModuleEnable = 1'b1;
        @(posedge clock);
        @(negedge clock);
        startReq = 1'b0;
        @(negedge clock);
        chk("wait_busy", op_busy, 1);
        chk("wait_addr1", op_readAddr1, 11'h123);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mrst_busy", op_busy, 0);
        chk("mrst_done", op_readDone, 0);
        chk("mrst_vals", {op_diagVal, op_nonDiagVal}, 0);
        chk("mrst_addr", {op_readAddr1, op_readAddr2}, {11'h7ff, 11'h7ff});
        repeat (6) begin
            @(negedge clock);
            chk("mrst_nodone", op_readDone, 0);
        end
        run_req(11'h012, 11'h034, 4'b0001, 4'b0100, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_read_y.md
# bus_read_y

Read-side counterpart of the Y-matrix row writer: fetches the two Y SRAM rows named by a diagonal and a non-diagonal address, and extracts one complex element from each using the 4-bit one-hot slot selects. The control path uses the extracted values as the current Y entries before a change-file update. It sits between the Y-update control path and the bus arbiter's read ports. It drives read addresses only while the round-robin grant (`inModuleEnable`) is held.

## Interface
- `ADDR_W`, 11, Y SRAM address width
- `DATA_W`, 256, Y SRAM row width
- `SLOT_W`, 64, bits per row slot (4 slots per row)
- `ELEM_W`, 48, complex element width: {real[47:24], img[23:0]}
- `READ_LAT`, 1, SRAM cycles from address to read data (≥1)
- `IDLE_ADDR`, 11'h7ff, address driven when not reading

Ports:
- `clock`  in  1  single clock; all logic rising-edge
- `reset`  in  1  synchronous, active-high
- `inModuleEnable`  in  1  bus grant from round-robin
- `startReq`  in  1  request strobe
- `inDiagAddr`  in  11  row address of diagonal element
- `inNonDAddr`  in  11  row address of non-diagonal element
- `inDiagOH`  in  4  one-hot slot select, diagonal
- `inNonDiagOH`  in  4  one-hot slot select, non-diagonal
- `inYreadData1`  in  256  read bus 1 (diagonal row)
- `inYreadData2`  in  256  read bus 2 (non-diagonal row)
- `op_readAddr1`  out  11  read address port 1
- `op_readAddr2`  out  11  read address port 2
- `op_diagVal`  out  48  extracted diagonal element
- `op_nonDiagVal`  out  48  extracted non-diagonal element
- `op_readDone`  out  1  one-cycle pulse; values valid
- `op_busy`  out  1  high in any state except IDLE
- `op_ohError`  out  1  sticky until next accept; a one-hot input was invalid

## Operation
- States: IDLE, ISSUE, WAIT, CAPTURE, DONE.
- IDLE:
  - When `startReq`=1, register both addresses and both one-hot selects.
  - If either select is not exactly one-hot (0000 or ≥2 bits set), go to DONE. In that case set `op_ohError`=1, drive both values 0, and make no SRAM access.
  - Otherwise clear `op_ohError` and go to ISSUE.
- ISSUE: drive the registered addresses on `op_readAddr1`/`op_readAddr2`.
  - If `inModuleEnable`=1, load the latency counter with `READ_LAT`-1 and go to WAIT, or go straight to CAPTURE when `READ_LAT`=1.
  - Otherwise stay in ISSUE.
- WAIT: addresses held. Decrement the counter each cycle; go to CAPTURE when it reaches 0.
- CAPTURE: sample the read buses.
  - Slot k occupies bits [64k+63:64k]; the element is the low 48 bits of the slot. Bits [64k+63:64k+48] are ignored.
  - `op_diagVal` ← slot of `inYreadData1` selected by `inDiagOH`; `op_nonDiagVal` ← slot of `inYreadData2` selected by `inNonDiagOH`.
  - Go to DONE.
- Grant loss: if `inModuleEnable`=0 in any WAIT or CAPTURE cycle, discard the read, capture nothing, and return to ISSUE. Addresses remain driven.
- DONE: `op_readDone`=1 for exactly one cycle, then return to IDLE.
- `op_diagVal`, `op_nonDiagVal` and `op_ohError` hold their values until the next accepted request.
- Equal diagonal and non-diagonal addresses are legal; each port is read independently.
- `startReq` is ignored while `op_busy`=1. It is accepted again in IDLE, including the cycle right after DONE.

## Timing
- Reset values: state IDLE; `op_readAddr1`=`op_readAddr2`=`IDLE_ADDR`; `op_diagVal`=`op_nonDiagVal`=0; `op_readDone`=`op_busy`=`op_ohError`=0; counter 0.
- Reset mid-operation returns to IDLE next edge. No done pulse is issued; captured values are cleared to 0.
- Outputs are registered. Addresses equal `IDLE_ADDR` in IDLE and DONE.
- Latency with the grant held: request sampled at edge T, ISSUE at T+1, `op_readDone` high at T+2+`READ_LAT`. With `READ_LAT`=1, done is at T+3.
- Each cycle the grant is absent in ISSUE adds 1 cycle.
- Invalid one-hot: `op_readDone` is high at T+1 with `op_ohError`=1.
- `op_busy` goes high the cycle after the request is accepted and drops in the cycle after DONE.

## Test plan
- Reset, then idle: addresses 7FF, all other outputs 0, `op_busy`=0.
- Start with diag addr 0x012, OH 0001; non-diag addr 0x034, OH 0100; grant held; row1 slot0 = 0x000A_BCDE_F012_3456, row2 slot2 = 0x0000_1111_2222_3333 → addresses 0x012/0x034 at T+1, `op_diagVal`=0xBCDEF0123456, `op_nonDiagVal`=0x111122223333, done pulse at T+3.
- Grant low for 3 ISSUE cycles, then high → done at T+6, addresses stable throughout. A grant drop in CAPTURE causes a reissue with no early done.
- Diag OH 0011 → done at T+1, `op_ohError`=1, both values 0, addresses remain 7FF. The next valid request clears the error.
- `startReq` pulsed every cycle during a transfer → exactly one done per accepted request, and the mid-transfer strobes are ignored.
- Reset asserted in WAIT with `READ_LAT`=3 → IDLE next cycle, no `op_readDone`, values 0.
